// File: rtl/pixel_quantizer_loader.sv
// rtl/pixel_quantizer_loader.sv - streams one 64x64 frame into the 6-bit feature memory.
// Define PIX_QUANT_ROUND_EN for round-to-nearest quantization (default: truncate).
module pixel_quantizer_loader #(
    parameter int PIX_W  = 8,
    parameter int Q_W    = 6,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              pix_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [Q_W-1:0]    mem_wdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

    localparam int SH = PIX_W - Q_W;
    localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [PIX_W:0]  Q_MAX = (PIX_W+1)'((1 << Q_W) - 1);
`ifdef PIX_QUANT_ROUND_EN
    localparam logic [PIX_W:0]  RND   = (PIX_W+1)'(1 << (SH - 1));
`else
    localparam logic [PIX_W:0]  RND   = '0;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [Q_W-1:0]    mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // One extra sum bit so the rounding offset can carry past the top; saturate back to Q_W.
    logic [PIX_W:0]    q_sum;
    logic [PIX_W:0]    q_shr;
    logic [Q_W-1:0]    q_val;

    assign q_sum = {1'b0, pix_data} + RND;
    assign q_shr = q_sum >> SH;
    assign q_val = (q_shr > Q_MAX) ? Q_MAX[Q_W-1:0] : q_shr[Q_W-1:0];

    assign pix_ready = (state_q == S_LOAD);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                if (pix_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q[ADDR_W-1:0];
                    mem_wdata_d = q_val;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_pixel_quantizer_loader.sv
// tb/tb_pixel_quantizer_loader.sv - scoreboard bench for pixel_quantizer_loader.
module tb_pixel_quantizer_loader;

    localparam int DEPTH = 4096;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        pix_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [5:0]  mem_wdata;
    logic        busy;
    logic        done;

    pixel_quantizer_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [11:0] a;
        logic [5:0]  d;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   exp_addr = 0;
    int   cd = 0;
    int   writes = 0;
    int   done_seen = 0;
    int   mode_q = 0;
    logic [7:0] qin [5];
    logic [5:0] qexp [5];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] quant(input logic [7:0] p);
        int v;
`ifdef PIX_QUANT_ROUND_EN
        v = (int'(p) + 2) / 4;
        if (v > 63) v = 63;
`else
        v = int'(p) / 4;
`endif
        return 6'(v);
    endfunction

    // Monitor: checks each cycle's write against the scoreboard, then records the beat due at the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            exp_addr = 0;
            cd = 0;
        end else begin
            check("mem_we", mem_we, (sb.size() > 0) ? 1 : 0);
            if (mem_we && sb.size() > 0) begin
                e = sb.pop_front();
                check("mem_addr", mem_addr, e.a);
                check("mem_wdata", mem_wdata, e.d);
                if (mode_q == 3 && e.a < 5) check("quant_tbl", mem_wdata, qexp[e.a]);
                writes++;
            end
            if (cd > 0) cd++;
            check("done", done, (cd == 3) ? 1 : 0);
            if (done) done_seen++;
            if (cd == 3) check("busy_in_done", busy, 1);
            if (cd == 4) begin
                check("busy_after_done", busy, 0);
                cd = 0;
                exp_addr = 0;
            end
            if (pix_valid && pix_ready) begin
                sb.push_back({12'(exp_addr), quant(pix_data)});
                if (exp_addr == DEPTH - 1) cd = 1;
                exp_addr++;
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ready"}, pix_ready, 0);
    endtask

    task automatic run_frame(input int mode, input int stop_at);
        int idx = 0;
        bit fin = 0;
        mode_q = mode;
        writes = 0;
        done_seen = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check("busy_on_start", busy, 1);
        check("ready_on_start", pix_ready, 1);
        for (int c = 0; c < 10000 && !fin; c++) begin
            pix_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_data  = (mode == 3 && idx < 5) ? qin[idx] : idx[7:0];
            start     = (mode == 2 && idx == 100);
            @(negedge clk);
            if (pix_valid && pix_ready) idx++;
            if (stop_at >= 0 && idx == stop_at) begin
                @(posedge clk); #2 rst_n = 1'b0;
                #1 check_outputs_zero("mid_reset");
                pix_valid = 1'b0;
                start = 1'b0;
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            if (done) begin
                fin = 1;
                if (mode == 2) start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
        end
        pix_valid = 1'b0;
        start = 1'b0;
        check("frame_done", fin, 1);
        repeat (4) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_ready", pix_ready, 0);
        check("pix_count", idx, DEPTH);
        check("write_count", writes, DEPTH);
        check("done_count", done_seen, 1);
    endtask

    initial begin
        qin[0] = 8'd0; qin[1] = 8'd1; qin[2] = 8'd2; qin[3] = 8'd253; qin[4] = 8'd255;
`ifdef PIX_QUANT_ROUND_EN
        qexp[0] = 6'd0; qexp[1] = 6'd0; qexp[2] = 6'd1; qexp[3] = 6'd63; qexp[4] = 6'd63;
`else
        qexp[0] = 6'd0; qexp[1] = 6'd0; qexp[2] = 6'd0; qexp[3] = 6'd63; qexp[4] = 6'd63;
`endif
        rst_n = 1'b0;
        start = 1'b0;
        pix_valid = 1'b1;
        pix_data = 8'hAA;
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 check_outputs_zero("idle");
        pix_valid = 1'b0;

        run_frame(0, -1);
        run_frame(1, -1);
        run_frame(2, -1);
        run_frame(0, 2000);
        check("after_reset_busy", busy, 0);
        run_frame(0, -1);
        run_frame(3, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
